// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - ALU_CONTROL_* codes for the six HI/LO operations and the code width.
//     These mirror the decoder's shared head.v definitions.
//   - MULDIV_ST_* 2-bit FSM encoding and the matching state enum.
//   - step_mode_e selecting shift-add or restoring-divide in muldiv_step.
//   - is_hilo_code(): true for any of the six codes this unit acts on.
package hilo_muldiv_pkg;

  localparam int ALU_CONTROL_LENGTH = 5;

  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULTU = 5'd16;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_DIVU  = 5'd17;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTHI  = 5'd18;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTLO  = 5'd19;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFHI  = 5'd20;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFLO  = 5'd21;

  localparam logic [1:0] MULDIV_ST_IDLE = 2'd0;
  localparam logic [1:0] MULDIV_ST_MUL  = 2'd1;
  localparam logic [1:0] MULDIV_ST_DIV  = 2'd2;
  localparam logic [1:0] MULDIV_ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = MULDIV_ST_IDLE,
    ST_MUL  = MULDIV_ST_MUL,
    ST_DIV  = MULDIV_ST_DIV,
    ST_DONE = MULDIV_ST_DONE
  } muldiv_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_hilo_code(input logic [ALU_CONTROL_LENGTH-1:0] code);
    return code inside {ALU_CONTROL_MULTU, ALU_CONTROL_DIVU, ALU_CONTROL_MTHI,
                        ALU_CONTROL_MTLO, ALU_CONTROL_MFHI, ALU_CONTROL_MFLO};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative multiply/divide.
//   mode_i  : STEP_MUL (shift-add) or STEP_DIV (restoring divide)
//   acc_i   : partial accumulator (product high half / partial remainder)
//   opnd_i  : operand register (multiplier+product low half / dividend+quotient)
//   m_i     : multiplicand or divisor, constant across the operation
//   acc_o, opnd_o : values for the next iteration
// After WIDTH iterations {acc, opnd} holds {product_hi, product_lo} for a
// multiply, or {remainder, quotient} for a divide.
module muldiv_step
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  step_mode_e       mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opnd_o
);

  logic [WIDTH:0] sum;      // accumulator plus conditional multiplicand, with carry
  logic [WIDTH:0] shifted;  // remainder shifted left with the next dividend bit
  logic [WIDTH:0] diff;     // trial subtraction; MSB set means it went negative

  assign sum     = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, m_i} : '0);
  assign shifted = {acc_i, opnd_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, m_i};

  always_comb begin
    // NOTE: both outputs get a default before any branch so no latch is inferred.
    acc_o  = acc_i;
    opnd_o = opnd_i;
    if (mode_i == STEP_MUL) begin
      // The carry shifts into the accumulator; the accumulator LSB moves into
      // the vacated top of the multiplier register.
      acc_o  = sum[WIDTH:1];
      opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
    end else begin
      // A zero divisor always "fits", giving an all-ones quotient and the
      // dividend as the remainder.
      if (!diff[WIDTH]) begin
        acc_o  = diff[WIDTH-1:0];
        opnd_o = {opnd_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o  = shifted[WIDTH-1:0];
        opnd_o = {opnd_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle unsigned MULTU/DIVU unit with the HI/LO pair,
// plus single-cycle MTHI/MTLO/MFHI/MFLO.
//   clk, rst_n    : clock, synchronous active-low reset
//   req           : EX holds a valid instruction
//   alu_control   : decoded operation code
//   src_a, src_b  : rs / rt operand values
//   stall         : HI/LO request while busy; EX must hold and re-present
//   busy          : iterative operation in flight
//   done          : one-cycle pulse when a MULTU/DIVU result is in HI/LO
//   hilo_rdata    : HI for MFHI, otherwise LO
//   hi, lo        : architectural HI/LO values
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req,
  input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
  input  logic [WIDTH-1:0]              src_a,
  input  logic [WIDTH-1:0]              src_b,
  output logic                          stall,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              hilo_rdata,
  output logic [WIDTH-1:0]              hi,
  output logic [WIDTH-1:0]              lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, opnd_q, m_q;
  logic [WIDTH-1:0] acc_d, opnd_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic       hilo_op;
  logic       accept;
  step_mode_e step_mode;

  assign hilo_op   = req && is_hilo_code(alu_control);
  assign stall     = hilo_op && busy_q;
  assign accept    = hilo_op && !busy_q;
  assign step_mode = (state_q == ST_DIV) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (step_mode),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .m_i    (m_q),
    .acc_o  (acc_d),
    .opnd_o (opnd_d)
  );

  // NOTE: acc/opnd/m are pure datapath, always reloaded on acceptance, so they
  // carry no reset; only the architectural and control state is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      done_q <= 1'b0;
      case (state_q)
        ST_MUL, ST_DIV: begin
          acc_q  <= acc_d;
          opnd_q <= opnd_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            // Both modes leave {hi, lo} in {acc, opnd} after the last step.
            hi_q    <= acc_d;
            lo_q    <= opnd_d;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin  // IDLE and DONE accept requests identically
          state_q <= ST_IDLE;
          if (accept) begin
            case (alu_control)
              ALU_CONTROL_MULTU: begin
                acc_q   <= '0;
                opnd_q  <= src_b;
                m_q     <= src_a;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_MUL;
              end
              ALU_CONTROL_DIVU: begin
                acc_q   <= '0;
                opnd_q  <= src_a;
                m_q     <= src_b;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_DIV;
              end
              ALU_CONTROL_MTHI: hi_q <= src_a;
              ALU_CONTROL_MTLO: lo_q <= src_a;
              default: ;  // MFHI/MFLO only read
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    hilo_rdata = lo_q;
    if (req && alu_control == ALU_CONTROL_MFHI) hilo_rdata = hi_q;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed literal checks from the test plan followed by
// randomized traffic, with a cycle-level behavioural model compared against
// every DUT output on every cycle after the first reset.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_ADD = 5'd0;
  localparam logic [ALU_CONTROL_LENGTH-1:0] ALU_SUB = 5'd3;

  logic                          clk;
  logic                          rst_n;
  logic                          req;
  logic [ALU_CONTROL_LENGTH-1:0] alu_control;
  logic [31:0]                   src_a, src_b;
  logic                          stall, busy, done;
  logic [31:0]                   hilo_rdata, hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .hilo_rdata  (hilo_rdata),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_left counts busy cycles still to run; the result is computed with plain
  // arithmetic at acceptance and lands when the countdown expires.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;
  logic        m_done;
  logic        m_op;

  always @(negedge clk) begin
    m_op = req && (alu_control inside {ALU_CONTROL_MULTU, ALU_CONTROL_DIVU, ALU_CONTROL_MTHI,
                                       ALU_CONTROL_MTLO, ALU_CONTROL_MFHI, ALU_CONTROL_MFLO});
    if (chk_en) begin
      check("busy",  {63'd0, busy},  {63'd0, (m_left > 0)});
      check("done",  {63'd0, done},  {63'd0, m_done});
      check("stall", {63'd0, stall}, {63'd0, (m_op && m_left > 0)});
      check("hi",    {32'd0, hi},    {32'd0, m_hi});
      check("lo",    {32'd0, lo},    {32'd0, m_lo});
      check("hilo_rdata", {32'd0, hilo_rdata},
            {32'd0, (req && alu_control == ALU_CONTROL_MFHI) ? m_hi : m_lo});
    end
    // Advance the model with the inputs held for the coming edge.
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          m_hi   = m_res[63:32];
          m_lo   = m_res[31:0];
          m_done = 1'b1;
        end
        m_left--;
      end else if (m_op) begin
        if (alu_control == ALU_CONTROL_MULTU) begin
          m_res  = {32'd0, src_a} * {32'd0, src_b};
          m_left = 32;
        end else if (alu_control == ALU_CONTROL_DIVU) begin
          m_res  = (src_b == 0) ? {src_a, 32'hFFFF_FFFF} : {src_a % src_b, src_a / src_b};
          m_left = 32;
        end else if (alu_control == ALU_CONTROL_MTHI) begin
          m_hi = src_a;
        end else if (alu_control == ALU_CONTROL_MTLO) begin
          m_lo = src_a;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; alu_control = ALU_ADD; src_a = '0; src_b = '0;
  endtask

  // Presents an op for one cycle; returns one cycle after the accepting edge.
  task automatic issue(input logic [ALU_CONTROL_LENGTH-1:0] code, input logic [31:0] a,
                       input logic [31:0] b);
    req = 1'b1; alu_control = code; src_a = a; src_b = b;
    tick();
    idle_inputs();
  endtask

  // Waits (bounded) for done; lat is the cycle index in which done is seen.
  task automatic wait_done(input int start, output int lat, output int nbusy);
    lat = start; nbusy = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) nbusy++;
      tick();
      lat++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom % 4)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  logic [ALU_CONTROL_LENGTH-1:0] codes [8];
  int lat, nbusy, ndone;

  initial begin
    codes = '{ALU_CONTROL_MULTU, ALU_CONTROL_DIVU, ALU_CONTROL_MTHI, ALU_CONTROL_MTLO,
              ALU_CONTROL_MFHI, ALU_CONTROL_MFLO, ALU_ADD, ALU_SUB};
    idle_inputs();
    rst_n = 1'b0;
    m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_res = '0;

    // Reset held for two edges.
    tick(); tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    req = 1'b1; alu_control = ALU_CONTROL_MFHI;
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    idle_inputs();
    tick();

    // MULTU max.
    issue(ALU_CONTROL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, nbusy);
    check("mul_max_latency", lat, 64'd33);
    check("mul_max_busy_cycles", nbusy, 64'd32);
    check("mul_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
    check("mul_max_lo", {32'd0, lo}, 64'h0000_0001);
    check("mul_max_busy_done", {63'd0, busy}, 64'd0);
    tick();

    // DIVU 100 / 7, then 5 / 0.
    issue(ALU_CONTROL_DIVU, 32'd100, 32'd7);
    wait_done(1, lat, nbusy);
    check("div_latency", lat, 64'd33);
    check("div_lo", {32'd0, lo}, 64'd14);
    check("div_hi", {32'd0, hi}, 64'd2);
    tick();
    issue(ALU_CONTROL_DIVU, 32'd5, 32'd0);
    wait_done(1, lat, nbusy);
    check("div0_latency", lat, 64'd33);
    check("div0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'd5);
    tick();

    // MTHI then MFHI on the next cycle.
    issue(ALU_CONTROL_MTHI, 32'h1234_5678, 32'd0);
    req = 1'b1; alu_control = ALU_CONTROL_MFHI;
    #1;
    check("mfhi_after_mthi", {32'd0, hilo_rdata}, 64'h1234_5678);
    idle_inputs();
    tick();

    // MTLO at cycle 5 of a MULTU stalls and leaves LO alone.
    issue(ALU_CONTROL_MULTU, 32'd7, 32'd9);
    repeat (4) tick();
    req = 1'b1; alu_control = ALU_CONTROL_MTLO; src_a = 32'hAAAA_AAAA;
    #1;
    check("mtlo_busy_stall", {63'd0, stall}, 64'd1);
    tick();
    idle_inputs();
    check("mtlo_busy_lo_kept", {32'd0, lo}, 64'hFFFF_FFFF);
    wait_done(6, lat, nbusy);
    check("mul_stall_latency", lat, 64'd33);
    check("mul_stall_lo", {32'd0, lo}, 64'd63);
    check("mul_stall_hi", {32'd0, hi}, 64'd0);
    tick();

    // Reset in the middle of a DIVU.
    issue(ALU_CONTROL_DIVU, 32'd1000, 32'd3);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("midrst_no_done", ndone, 64'd0);

    // Back-to-back MULTU: second presented in the DONE cycle.
    issue(ALU_CONTROL_MULTU, 32'd3, 32'd4);
    wait_done(1, lat, nbusy);
    check("b2b_first_latency", lat, 64'd33);
    check("b2b_first_lo", {32'd0, lo}, 64'd12);
    req = 1'b1; alu_control = ALU_CONTROL_MULTU; src_a = 32'd5; src_b = 32'd6;
    tick();
    idle_inputs();
    check("b2b_busy_again", {63'd0, busy}, 64'd1);
    wait_done(1, lat, nbusy);
    check("b2b_second_latency", lat, 64'd33);
    check("b2b_second_lo", {32'd0, lo}, 64'd30);
    check("b2b_second_hi", {32'd0, hi}, 64'd0);
    tick();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom % 600 != 0);
      req         = ($urandom % 8 != 0);
      alu_control = codes[$urandom % 8];
      src_a       = pick_operand();
      src_b       = pick_operand();
      tick();
    end
    idle_inputs();
    rst_n = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle unsigned multiply/divide unit with the architectural HI/LO register pair, sitting in the EX stage beside the single-cycle ALU. It consumes the decoded `alu_control` code produced by the ALU control decoder. It executes MULTU, DIVU, MTHI, MTLO, MFHI and MFLO, and drives a stall back to the pipeline while an iterative operation is in flight.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req` in 1: EX stage holds a valid instruction this cycle.
- `alu_control` in `ALU_CONTROL_LENGTH`: decoded operation code; only the six HI/LO codes listed above are acted on.
- `src_a` in `WIDTH`: rs value (multiplicand, dividend, or MTHI/MTLO data).
- `src_b` in `WIDTH`: rt value (multiplier or divisor).
- `stall` out 1: combinational; the pipeline must hold EX and re-present the instruction.
- `busy` out 1: an iterative operation is in progress.
- `done` out 1: one-cycle pulse; the MULTU/DIVU result is now in HI/LO.
- `hilo_rdata` out `WIDTH`: MFHI/MFLO result; combinational from the HI/LO registers.
- `hi`, `lo` out `WIDTH` each: current architectural register values.

## Operation
- `hilo_op` = `req` and `alu_control` is one of MULTU, DIVU, MTHI, MTLO, MFHI, MFLO. All other codes are ignored: no state change, and `stall` stays 0.
- `stall` = `hilo_op` and `busy`. A stalled request is ignored (no side effects) and is accepted when re-presented after `busy` falls.
- **FSM states:** IDLE, MUL, DIV, DONE.
  - IDLE/DONE → MUL on an accepted MULTU.
  - IDLE/DONE → DIV on an accepted DIVU.
  - MUL/DIV → DONE after iteration 31.
  - DONE → IDLE when no MULTU/DIVU is accepted.
  - DONE accepts requests exactly like IDLE.
- **Operand capture:** `src_a`/`src_b` are latched on acceptance. Later changes on the inputs have no effect on the operation.
- **MULTU:** shift-add, one bit per cycle, 5-bit iteration counter 0..31. The 64-bit unsigned product is written with HI = [63:32] and LO = [31:0].
- **DIVU:** restoring division, one quotient bit per cycle. LO = quotient, HI = remainder.
  - Divisor 0 is not special-cased: it runs the full 32 cycles and yields LO = 0xFFFF_FFFF, HI = dividend.
- **HI/LO update during MULTU/DIVU:** the registers are written only at the final iteration edge. `hi`/`lo` hold their old values while busy.
- **MTHI/MTLO (not busy):** HI (resp. LO) takes `src_a` at the next edge.
- **MFHI/MFLO (not busy):** `hilo_rdata` = `hi` (resp. `lo`) in the same cycle.
  - An MTHI followed by an MFHI on the next cycle reads the new value.
- When neither MFHI nor MFLO is requested, `hilo_rdata` = `lo`.

## Timing
- **Reset:** `rst_n` low at an edge forces state = IDLE, counter = 0, HI = LO = 0, `busy` = 0, `done` = 0, in any state. An operation in flight is discarded and produces no `done` pulse.
- **MULTU/DIVU accepted in cycle 0:**
  - `busy` = 1 in cycles 1..32.
  - HI/LO take the new values at the edge ending cycle 32.
  - `done` = 1 and `busy` = 0 in cycle 33.
  - Total latency is 33 cycles.
- **Back-to-back:** a new MULTU/DIVU presented in the DONE cycle is accepted, so `busy` rises again in the following cycle. The throughput is one operation per 33 cycles.
- **Single-cycle ops:** MTHI/MTLO/MFHI/MFLO complete in one cycle with no `busy` assertion. An MTHI/MTLO in the DONE cycle overwrites the just-written value at the next edge.
- **Request while busy:** `stall` = 1 in the same cycle. HI/LO, the FSM and the counter are unaffected.

## Structure
- **Shared include `head.v`** (not local to this block):
  - the `ALU_CONTROL_*` codes for MULTU, DIVU, MTHI, MTLO, MFHI, MFLO;
  - `ALU_CONTROL_LENGTH`;
  - the FSM state encoding `MULDIV_ST_*`, 2 bits.
- **One sub-module, `muldiv_step`:** combinational, one iteration of shift-add or restoring-divide selected by a mode bit. It takes {partial accumulator, operand register} and returns their next values.
- **Parent `hilo_muldiv`** owns the FSM, counter, operand registers, HI/LO, and the stall/`hilo_rdata` logic.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles, then release → `hi` = `lo` = 0, `busy` = 0, `done` = 0, `stall` = 0.
- **MULTU max:** MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `busy` in cycles 1–32, `done` in cycle 33, HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- **DIVU:** DIVU 100 / 7 → LO = 14, HI = 2. Then DIVU 5 / 0 → LO = 0xFFFF_FFFF, HI = 5, each after 33 cycles.
- **Move ops and stall:**
  - MTHI 0x1234_5678, then MFHI next cycle → `hilo_rdata` = 0x1234_5678.
  - MTLO 0xAAAA_AAAA at cycle 5 of a MULTU → `stall` = 1, LO unchanged until the MULTU result lands.
- **Reset mid-operation:** DIVU 1000 / 3, `rst_n` = 0 at cycle 10 → IDLE next cycle, HI = LO = 0, no `done` pulse ever.
- **Back-to-back:** MULTU 3 × 4, then MULTU 5 × 6 presented in its DONE cycle → first `done` with LO = 12, second `done` 33 cycles later with LO = 30, HI = 0.
